// File: rtl/cache_pkg.sv
// Shared types and helpers for the direct-mapped write-through cache controller.
package cache_pkg;

  localparam int ADDR_W_DEF  = 10;
  localparam int DATA_W_DEF  = 32;
  localparam int INDEX_W_DEF = 5;
  localparam int STAT_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    HIT_RD,
    MEM_REQ,
    MEM_WAIT,
    FILL,
    RESP
  } state_e;

  // Widths are passed at run time so callers with overridden parameters stay correct.
  function automatic logic [31:0] get_index(input logic [31:0] addr, input int index_w);
    return addr & ((32'd1 << index_w) - 32'd1);
  endfunction

  function automatic logic [31:0] get_tag(input logic [31:0] addr, input int index_w);
    return addr >> index_w;
  endfunction

endpackage

// File: rtl/cache_tag_array.sv
// Tag/valid store: one entry per line, combinational read, synchronous write,
// valid bits cleared synchronously by gen_reset.
module cache_tag_array
  import cache_pkg::*;
#(
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int TAG_W   = ADDR_W_DEF - INDEX_W_DEF
) (
  input  logic               clk,
  input  logic               gen_reset,
  input  logic [INDEX_W-1:0] rd_index,
  output logic [TAG_W-1:0]   rd_tag,
  output logic               rd_valid,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag
);

  localparam int DEPTH = 1 << INDEX_W;

  logic [TAG_W-1:0] tag_q   [DEPTH];
  logic [TAG_W-1:0] tag_d   [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  always_comb begin
    tag_d   = tag_q;
    valid_d = valid_q;
    if (wr_en) begin
      tag_d[wr_index]   = wr_tag;
      valid_d[wr_index] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (gen_reset) valid_q <= '0;
    else           valid_q <= valid_d;
  end

  // Tags are only meaningful behind a set valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  assign rd_tag   = tag_q[rd_index];
  assign rd_valid = valid_q[rd_index];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller driving a BloqueCache data block.
// Optional hit/miss counters are built when CACHE_CTRL_STATS_EN is defined.
//
// state    | meaning
// IDLE     | ready for a CPU request
// LOOKUP   | tag compare on latched address; read hit issues cache_re, write hit issues cache_we
// HIT_RD   | return cache_rdata to CPU
// MEM_REQ  | present request to memory until accepted
// MEM_WAIT | wait for memory read data or write ack
// FILL     | write fetched word and tag into the cache
// RESP     | one-cycle CPU response for misses and writes
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int INDEX_W = INDEX_W_DEF
) (
  input  logic              clk,
  input  logic              gen_reset,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_resp_rdata,
  output logic              cpu_resp_hit,
  output logic              cache_we,
  output logic              cache_re,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_wdata,
  input  logic [DATA_W-1:0] cache_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic [STAT_W-1:0] stat_hits,
  output logic [STAT_W-1:0] stat_misses
);

  localparam int TAG_W = ADDR_W - INDEX_W;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                hit_q, hit_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    tag;
  logic [TAG_W-1:0]    rd_tag;
  logic                rd_valid;
  logic                lookup_hit;
  logic                tag_wr_en;

  assign index      = INDEX_W'(get_index(32'(addr_q), INDEX_W));
  assign tag        = TAG_W'(get_tag(32'(addr_q), INDEX_W));
  assign lookup_hit = rd_valid && (rd_tag == tag);
  assign tag_wr_en  = (state_q == FILL) && !gen_reset;

  cache_tag_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_tag_array (
    .clk       (clk),
    .gen_reset (gen_reset),
    .rd_index  (index),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .wr_en     (tag_wr_en),
    .wr_index  (index),
    .wr_tag    (tag)
  );

  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    hit_d          = hit_q;
    rdata_d        = rdata_q;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_rdata = '0;
    cpu_resp_hit   = 1'b0;
    cache_we       = 1'b0;
    cache_re       = 1'b0;
    cache_addr     = '0;
    cache_wdata    = '0;
    mem_req_valid  = 1'b0;
    mem_req_we     = 1'b0;
    mem_req_addr   = '0;
    mem_req_wdata  = '0;

    case (state_q)
      IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) begin
          we_d    = cpu_req_we;
          addr_d  = cpu_req_addr;
          wdata_d = cpu_req_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        hit_d      = lookup_hit;
        cache_addr = ADDR_W'(index);
        if (!we_q) begin
          cache_re = lookup_hit;
          state_d  = lookup_hit ? HIT_RD : MEM_REQ;
        end else begin
          // No write-allocate: a write miss leaves the data block untouched.
          cache_we    = lookup_hit;
          cache_wdata = lookup_hit ? wdata_q : '0;
          state_d     = MEM_REQ;
        end
        if (!cache_we && !cache_re) cache_addr = '0;
      end
      HIT_RD: begin
        cpu_resp_valid = 1'b1;
        cpu_resp_rdata = cache_rdata;
        cpu_resp_hit   = 1'b1;
        state_d        = IDLE;
      end
      MEM_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = we_q;
        mem_req_addr  = addr_q;
        mem_req_wdata = we_q ? wdata_q : '0;
        if (mem_req_ready) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_resp_valid) begin
          rdata_d = mem_resp_rdata;
          state_d = we_q ? RESP : FILL;
        end
      end
      FILL: begin
        cache_we    = 1'b1;
        cache_addr  = ADDR_W'(index);
        cache_wdata = rdata_q;
        state_d     = RESP;
      end
      RESP: begin
        cpu_resp_valid = 1'b1;
        cpu_resp_rdata = we_q ? '0 : rdata_q;
        cpu_resp_hit   = hit_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are forced quiet for the whole reset window, not just after the edge.
    if (gen_reset) begin
      cpu_req_ready  = 1'b0;
      cpu_resp_valid = 1'b0;
      cpu_resp_rdata = '0;
      cpu_resp_hit   = 1'b0;
      cache_we       = 1'b0;
      cache_re       = 1'b0;
      cache_addr     = '0;
      cache_wdata    = '0;
      mem_req_valid  = 1'b0;
      mem_req_we     = 1'b0;
      mem_req_addr   = '0;
      mem_req_wdata  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (gen_reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hit_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hit_q   <= hit_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  logic [STAT_W-1:0] hits_q, hits_d;
  logic [STAT_W-1:0] misses_q, misses_d;

  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (state_q == LOOKUP) begin
      if (lookup_hit) begin
        if (hits_q != '1) hits_d = hits_q + 1'b1;
      end else begin
        if (misses_q != '1) misses_d = misses_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (gen_reset) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign stat_hits   = gen_reset ? '0 : hits_q;
  assign stat_misses = gen_reset ? '0 : misses_q;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a BloqueCache data-block model and a simple memory responder.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        gen_reset;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic        cpu_req_we;
  logic [9:0]  cpu_req_addr;
  logic [31:0] cpu_req_wdata;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_rdata;
  logic        cpu_resp_hit;
  logic        cache_we;
  logic        cache_re;
  logic [9:0]  cache_addr;
  logic [31:0] cache_wdata;
  logic [31:0] cache_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [9:0]  mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic [15:0] stat_hits;
  logic [15:0] stat_misses;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk            (clk),
    .gen_reset      (gen_reset),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_we     (cpu_req_we),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_rdata (cpu_resp_rdata),
    .cpu_resp_hit   (cpu_resp_hit),
    .cache_we       (cache_we),
    .cache_re       (cache_re),
    .cache_addr     (cache_addr),
    .cache_wdata    (cache_wdata),
    .cache_rdata    (cache_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .stat_hits      (stat_hits),
    .stat_misses    (stat_misses)
  );

  // BloqueCache data block: synchronous write, read data one cycle after cache_re.
  logic [31:0] blk [32];
  always @(posedge clk) begin
    if (cache_we) blk[cache_addr[4:0]] <= cache_wdata;
    if (cache_re) cache_rdata <= blk[cache_addr[4:0]];
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  logic        got, r_hit, mem_seen, mem_we_seen, stable_ok;
  logic        cwe_seen, cre_seen, both_seen;
  logic [31:0] r_rdata, cwe_data;
  logic [9:0]  cwe_addr;
  int          r_lat, req_cycles;

  task automatic run_txn(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                         input logic [31:0] mdata, input int ready_lat, input logic stray);
    int cd;
    got = 0; r_hit = 0; r_rdata = '0; r_lat = 0; mem_seen = 0; mem_we_seen = 0;
    stable_ok = 1; cwe_seen = 0; cre_seen = 0; both_seen = 0; cwe_data = '0; cwe_addr = '0;
    req_cycles = 0; cd = 0;
    @(negedge clk);
    check("ready_before_req", {31'd0, cpu_req_ready}, 32'd1);
    cpu_req_valid = 1; cpu_req_we = we; cpu_req_addr = addr; cpu_req_wdata = wdata;
    @(posedge clk); #1;
    cpu_req_valid = 0; cpu_req_we = ~we; cpu_req_addr = ~addr; cpu_req_wdata = ~wdata;
    for (int c = 1; c <= 60 && !got; c++) begin
      @(negedge clk);
      mem_resp_valid = 0;
      mem_req_ready  = 0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin mem_resp_valid = 1; mem_resp_rdata = mdata; end
      end
      if (cache_we && cache_re) both_seen = 1;
      if (cache_we) begin cwe_seen = 1; cwe_addr = cache_addr; cwe_data = cache_wdata; end
      if (cache_re) cre_seen = 1;
      if (mem_req_valid) begin
        mem_seen = 1; mem_we_seen = mem_req_we; req_cycles++;
        if (mem_req_addr !== addr || mem_req_we !== we || (we && mem_req_wdata !== wdata))
          stable_ok = 0;
        if (req_cycles > ready_lat) begin
          mem_req_ready = 1; cd = 2;
          if (stray) begin mem_resp_valid = 1; mem_resp_rdata = 32'hDEADBEEF; end
        end
      end
      if (cpu_resp_valid) begin
        got = 1; r_rdata = cpu_resp_rdata; r_hit = cpu_resp_hit; r_lat = c;
      end
    end
    check("resp_seen", {31'd0, got}, 32'd1);
    check("we_re_exclusive", {31'd0, both_seen}, 32'd0);
    @(negedge clk);
    mem_resp_valid = 0;
    check("resp_single_pulse", {31'd0, cpu_resp_valid}, 32'd0);
  endtask

  logic seen;

  initial begin
    gen_reset = 1; cpu_req_valid = 0; cpu_req_we = 0; cpu_req_addr = '0; cpu_req_wdata = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, cpu_req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, cpu_resp_valid}, 32'd0);
    check("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rst_cache_en", {30'd0, cache_we, cache_re}, 32'd0);
    @(posedge clk); #1 gen_reset = 0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, cpu_req_ready}, 32'd1);

    // 1: cold read miss, fill index 3
    run_txn(1'b0, 10'h003, 32'h0, 32'd15, 0, 1'b0);
    check("t1_rdata", r_rdata, 32'd15);
    check("t1_hit", {31'd0, r_hit}, 32'd0);
    check("t1_mem_seen", {31'd0, mem_seen}, 32'd1);
    check("t1_mem_we", {31'd0, mem_we_seen}, 32'd0);
    check("t1_mem_stable", {31'd0, stable_ok}, 32'd1);
    check("t1_fill_addr", {22'd0, cwe_addr}, 32'd3);
    check("t1_fill_data", cwe_data, 32'd15);

    // 2: read hit, two cycles after accept
    run_txn(1'b0, 10'h003, 32'h0, 32'h0, 0, 1'b0);
    check("t2_rdata", r_rdata, 32'd15);
    check("t2_hit", {31'd0, r_hit}, 32'd1);
    check("t2_latency", r_lat, 32'd2);
    check("t2_no_mem", {31'd0, mem_seen}, 32'd0);
    check("t2_cache_re", {31'd0, cre_seen}, 32'd1);

    // 3: write miss (no allocate), read miss fill, write hit, read hit
    run_txn(1'b1, 10'h011, 32'd25, 32'h0, 0, 1'b0);
    check("t3_wr_mem_we", {31'd0, mem_we_seen}, 32'd1);
    check("t3_wr_mem_stable", {31'd0, stable_ok}, 32'd1);
    check("t3_wr_no_cache_we", {31'd0, cwe_seen}, 32'd0);
    check("t3_wr_rdata", r_rdata, 32'd0);
    check("t3_wr_hit", {31'd0, r_hit}, 32'd0);
    run_txn(1'b0, 10'h011, 32'h0, 32'd25, 0, 1'b0);
    check("t3_rd_hit", {31'd0, r_hit}, 32'd0);
    check("t3_rd_rdata", r_rdata, 32'd25);
    run_txn(1'b1, 10'h011, 32'd40, 32'h0, 0, 1'b0);
    check("t3_whit_hit", {31'd0, r_hit}, 32'd1);
    check("t3_whit_cache_we", {31'd0, cwe_seen}, 32'd1);
    check("t3_whit_cache_addr", {22'd0, cwe_addr}, 32'h11);
    check("t3_whit_cache_data", cwe_data, 32'd40);
    check("t3_whit_mem_we", {31'd0, mem_we_seen}, 32'd1);
    check("t3_whit_rdata", r_rdata, 32'd0);
    run_txn(1'b0, 10'h011, 32'h0, 32'h0, 0, 1'b0);
    check("t3_rhit_hit", {31'd0, r_hit}, 32'd1);
    check("t3_rhit_rdata", r_rdata, 32'd40);

    // 4: conflicting tag on index 0x11 evicts
    run_txn(1'b0, 10'h031, 32'h0, 32'd99, 0, 1'b0);
    check("t4_evict_hit", {31'd0, r_hit}, 32'd0);
    check("t4_evict_rdata", r_rdata, 32'd99);
    run_txn(1'b0, 10'h011, 32'h0, 32'd40, 0, 1'b0);
    check("t4_reread_hit", {31'd0, r_hit}, 32'd0);
    check("t4_reread_mem", {31'd0, mem_seen}, 32'd1);

    // 5: memory stalls 4 cycles, stray response during handshake, stray in IDLE
    run_txn(1'b0, 10'h005, 32'h0, 32'h55, 4, 1'b1);
    check("t5_req_cycles", req_cycles, 32'd5);
    check("t5_stable", {31'd0, stable_ok}, 32'd1);
    check("t5_rdata", r_rdata, 32'h55);
    @(negedge clk);
    mem_resp_valid = 1; mem_resp_rdata = 32'hBAD;
    @(negedge clk);
    mem_resp_valid = 0;
    check("t5_idle_no_resp", {31'd0, cpu_resp_valid}, 32'd0);
    check("t5_idle_no_req", {31'd0, mem_req_valid}, 32'd0);
    check("t5_idle_ready", {31'd0, cpu_req_ready}, 32'd1);
    run_txn(1'b0, 10'h005, 32'h0, 32'h0, 0, 1'b0);
    check("t5_hit_after", {31'd0, r_hit}, 32'd1);
    check("t5_hit_rdata", r_rdata, 32'h55);
`ifdef CACHE_CTRL_STATS_EN
    check("stat_hits", {16'd0, stat_hits}, 32'd4);
    check("stat_misses", {16'd0, stat_misses}, 32'd6);
`endif

    // 6: reset while waiting on memory
    @(negedge clk);
    cpu_req_valid = 1; cpu_req_we = 0; cpu_req_addr = 10'h007;
    @(posedge clk); #1 cpu_req_valid = 0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (mem_req_valid) begin seen = 1; mem_req_ready = 1; end
    end
    check("t6_req_seen", {31'd0, seen}, 32'd1);
    @(negedge clk); mem_req_ready = 0;
    @(posedge clk); #1 gen_reset = 1;
    @(negedge clk);
    check("t6_rst_ready", {31'd0, cpu_req_ready}, 32'd0);
    check("t6_rst_outputs", {29'd0, cpu_resp_valid, mem_req_valid, cache_we}, 32'd0);
    check("t6_rst_stats", {stat_hits, stat_misses}, 32'd0);
    @(posedge clk); #1 gen_reset = 0;
    @(negedge clk);
    mem_resp_valid = 1; mem_resp_rdata = 32'h77;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mem_resp_valid = 0;
      if (cpu_resp_valid) seen = 1;
    end
    check("t6_no_resp", {31'd0, seen}, 32'd0);
    check("t6_ready", {31'd0, cpu_req_ready}, 32'd1);
    check("t6_stats_zero", {stat_hits, stat_misses}, 32'd0);
    run_txn(1'b0, 10'h003, 32'h0, 32'd15, 0, 1'b0);
    check("t6_reread_hit", {31'd0, r_hit}, 32'd0);
    check("t6_reread_mem", {31'd0, mem_seen}, 32'd1);
    check("t6_reread_rdata", r_rdata, 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
